// File: rtl/plot_engine.sv
// Pixel-plot back end: buffers packets from the init/game FSMs in a small
// command FIFO and expands each one into single-pixel writes to the VGA adapter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; pops the FIFO head into the working regs when non-empty
// PLOT  | presents pixel (x0+dx, y0+dy); dx is the fast index
module plot_engine #(
  parameter int DEPTH    = 8,
  parameter int BLOCK    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_init,
  input  logic        draw,
  input  logic [17:0] init_out,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy,
  output logic        full,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [2:0]    BLOCK_LAST = 3'(BLOCK - 1);
  localparam logic [2:0]    WALL       = 3'b111;
  localparam logic [8:0]    X_LIMIT    = 9'(SCREEN_W);
  localparam logic [7:0]    Y_LIMIT    = 8'(SCREEN_H);

  typedef enum logic {IDLE, PLOT} state_t;

  state_t state_q, state_d;

  logic [17:0]   pkt_q, pkt_d;
  logic [17:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic [2:0] col_q, col_d;
  logic [2:0] last_q, last_d;
  logic [2:0] dx_q, dx_d;
  logic [2:0] dy_q, dy_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        last_pixel;
  logic [17:0] head;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // A full FIFO rejects the push even if the engine pops in the same cycle.
  assign push       = draw && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q];
  assign last_pixel = (dx_q == last_q) && (dy_q == last_q);

  assign x_sum = {1'b0, x0_q} + {6'b0, dx_q};
  assign y_sum = {1'b0, y0_q} + {5'b0, dy_q};

  // Packet register and FIFO bookkeeping
  always_comb begin
    pkt_d      = load_init ? init_out : pkt_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);
    overflow_d = overflow_q || (draw && fifo_full);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= pkt_q;
  end

  // Working registers
  always_comb begin
    x0_d   = x0_q;
    y0_d   = y0_q;
    col_d  = col_q;
    last_d = last_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    if (pop) begin
      x0_d   = head[17:10];
      y0_d   = head[9:3];
      col_d  = head[2:0];
      last_d = (head[2:0] == WALL) ? 3'd0 : BLOCK_LAST;
      dx_d   = '0;
      dy_d   = '0;
    end else if (state_q == PLOT && !last_pixel) begin
      if (dx_q == last_q) begin
        dx_d = '0;
        dy_d = dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x0_q   <= '0;
      y0_q   <= '0;
      col_q  <= '0;
      last_q <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
    end else begin
      x0_q   <= x0_d;
      y0_q   <= y0_d;
      col_q  <= col_d;
      last_q <= last_d;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = PLOT;
      PLOT:    if (last_pixel)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The working regs are frozen in IDLE, so vga_* hold.
  always_comb begin
    vga_x      = x_sum[7:0];
    vga_y      = y_sum[6:0];
    vga_colour = col_q;
    plot       = (state_q == PLOT) && (x_sum < X_LIMIT) && (y_sum < Y_LIMIT);
    busy       = !fifo_empty || (state_q != IDLE);
    full       = fifo_full;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_plot_engine.sv
// Directed self-checking bench for plot_engine: wall, block, stream,
// overflow, clipping and mid-plot reset scenarios.
module tb_plot_engine;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load_init = 1'b0;
  logic        draw = 1'b0;
  logic [17:0] init_out = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        full;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] qx[$];
  logic [6:0] qy[$];
  logic [2:0] qc[$];
  int         qt[$];

  plot_engine #(.DEPTH(8), .BLOCK(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .resetn(resetn), .load_init(load_init), .draw(draw),
    .init_out(init_out), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every plotted pixel, sampled mid-cycle.
  always @(negedge clock) begin
    if (resetn && plot) begin
      qx.push_back(vga_x);
      qy.push_back(vga_y);
      qc.push_back(vga_colour);
      qt.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [17:0] pk(input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] c);
    return {x, y, c};
  endfunction

  task automatic clear_q;
    qx.delete(); qy.delete(); qc.delete(); qt.delete();
  endtask

  task automatic do_reset;
    resetn = 1'b0; load_init = 1'b0; draw = 1'b0;
    tick; tick;
    resetn = 1'b1;
    clear_q();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Load a packet, then draw it in the following cycle; returns in cycle t+1.
  task automatic load_draw(input logic [17:0] p);
    init_out = p; load_init = 1'b1;
    tick;
    load_init = 1'b0; draw = 1'b1;
    tick;
    draw = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    tick; tick;
    chk("rst_x", vga_x, 0);       chk("rst_y", vga_y, 0);
    chk("rst_col", vga_colour, 0); chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);     chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    resetn = 1'b1;
    tick;

    // Wall pixel
    load_draw(pk(8'd40, 7'd40, 3'b111));
    chk("wall_t1_plot", plot, 0);
    chk("wall_t1_busy", busy, 1);
    tick;
    chk("wall_plot", plot, 1);  chk("wall_x", vga_x, 40);
    chk("wall_y", vga_y, 40);   chk("wall_col", vga_colour, 7);
    tick;
    chk("wall_after_plot", plot, 0);
    chk("wall_after_busy", busy, 0);

    // Player block
    load_draw(pk(8'd80, 7'd79, 3'b001));
    for (int i = 0; i < 16; i++) begin
      tick;
      chk($sformatf("blk_plot%0d", i), plot, 1);
      chk($sformatf("blk_x%0d", i), vga_x, 80 + (i % 4));
      chk($sformatf("blk_y%0d", i), vga_y, 79 + (i / 4));
      chk($sformatf("blk_col%0d", i), vga_colour, 1);
    end
    tick;
    chk("blk_idle_plot", plot, 0);
    chk("blk_idle_x", vga_x, 83);
    chk("blk_idle_y", vga_y, 82);

    // Back-to-back stream of 9 walls
    clear_q();
    init_out = pk(8'd41, 7'd40, 3'b111); load_init = 1'b1;
    tick;
    for (int k = 1; k <= 9; k++) begin
      draw = 1'b1;
      load_init = (k < 9);
      init_out = pk(8'(41 + k), 7'd40, 3'b111);
      tick;
    end
    draw = 1'b0; load_init = 1'b0;
    wait_idle(100);
    chk("stream_count", qx.size(), 9);
    chk("stream_ovf", overflow, 0);
    for (int i = 0; i < qx.size() && i < 9; i++) begin
      chk($sformatf("stream_x%0d", i), qx[i], 41 + i);
      chk($sformatf("stream_y%0d", i), qy[i], 40);
      if (i > 0) chk($sformatf("stream_gap%0d", i), qt[i] - qt[i-1], 2);
    end

    // Overflow: block keeps the engine busy, then DEPTH+1 draws
    clear_q();
    init_out = pk(8'd10, 7'd10, 3'b001); load_init = 1'b1;
    tick;
    load_init = 1'b0; draw = 1'b1;
    tick;
    draw = 1'b0; init_out = pk(8'd100, 7'd5, 3'b111); load_init = 1'b1;
    tick;
    for (int k = 0; k < 9; k++) begin
      draw = 1'b1;
      load_init = (k < 8);
      init_out = pk(8'(101 + k), 7'd5, 3'b111);
      if (k == 7) chk("ovf_notfull_yet", full, 0);
      if (k == 8) begin
        chk("ovf_full", full, 1);
        chk("ovf_not_yet", overflow, 0);
      end
      tick;
    end
    draw = 1'b0; load_init = 1'b0;
    chk("ovf_sticky", overflow, 1);
    wait_idle(200);
    chk("ovf_total", qx.size(), 24);
    begin
      int walls = 0;
      int last_x = 0;
      for (int i = 0; i < qx.size(); i++)
        if (qc[i] == 3'b111) begin walls++; last_x = qx[i]; end
      chk("ovf_walls", walls, 8);
      chk("ovf_last_x", last_x, 107);
    end
    chk("ovf_still_set", overflow, 1);

    // Clipping at the bottom-right corner
    do_reset();
    chk("clip_ovf_cleared", overflow, 0);
    load_draw(pk(8'd158, 7'd118, 3'b100));
    for (int i = 0; i < 16; i++) begin
      tick;
      chk($sformatf("clip_plot%0d", i), plot, ((i % 4) < 2 && (i / 4) < 2) ? 1 : 0);
      chk($sformatf("clip_x%0d", i), vga_x, 158 + (i % 4));
      chk($sformatf("clip_y%0d", i), vga_y, 118 + (i / 4));
    end
    tick;
    chk("clip_end_plot", plot, 0);
    chk("clip_end_busy", busy, 0);

    // Carry-out of the coordinate sums, truncated on vga_*
    load_draw(pk(8'd254, 7'd126, 3'b010));
    for (int i = 0; i < 16; i++) begin
      tick;
      chk($sformatf("carry_plot%0d", i), plot, 0);
      chk($sformatf("carry_x%0d", i), vga_x, (254 + (i % 4)) % 256);
      chk($sformatf("carry_y%0d", i), vga_y, (126 + (i / 4)) % 128);
    end
    tick;
    chk("carry_end_busy", busy, 0);

    // Reset mid-plot with 3 queued entries
    init_out = pk(8'd20, 7'd20, 3'b010); load_init = 1'b1;
    tick;
    load_init = 1'b0; draw = 1'b1;
    tick;
    draw = 1'b0; init_out = pk(8'd60, 7'd60, 3'b111); load_init = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      draw = 1'b1;
      load_init = (k < 2);
      init_out = pk(8'(61 + k), 7'd60, 3'b111);
      tick;
    end
    draw = 1'b0; load_init = 1'b0;
    tick;
    chk("mid_pix5_plot", plot, 1);
    chk("mid_pix5_x", vga_x, 20);
    chk("mid_pix5_y", vga_y, 21);
    resetn = 1'b0;
    tick;
    chk("mid_rst_x", vga_x, 0);        chk("mid_rst_y", vga_y, 0);
    chk("mid_rst_col", vga_colour, 0); chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);      chk("mid_rst_full", full, 0);
    chk("mid_rst_ovf", overflow, 0);
    resetn = 1'b1;
    clear_q();
    for (int i = 0; i < 5; i++) tick;
    chk("mid_no_pixels", qx.size(), 0);
    chk("mid_fifo_empty", busy, 0);
    load_draw(pk(8'd30, 7'd30, 3'b111));
    chk("post_t1_plot", plot, 0);
    tick;
    chk("post_plot", plot, 1);
    chk("post_x", vga_x, 30);
    chk("post_y", vga_y, 30);
    chk("post_col", vga_colour, 7);
    tick;
    chk("post_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
